// File: rtl/lut4_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lut4_config_sequencer_if
// Purpose  : Truth-table offer handshake between a requester and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface lut4_config_sequencer_if;
    logic        i_cfg_valid;
    logic [15:0] i_cfg_word;
    logic        o_cfg_ready;

    modport master (
        output i_cfg_valid,
        output i_cfg_word,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_word,
        output o_cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/lut4_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lut4_config_sequencer
// Purpose  : Serialises a 16-bit truth table into a LUT4 config port.
//            Each address/data pair is held for HOLD_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lut4_config_sequencer #(
    parameter int HOLD_CYCLES = 2   // legal range 1..15
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    lut4_config_sequencer_if.slave        cfg,
    input  logic                          i_abort,
    output logic [3:0]                    o_addr_load_data,
    output logic                          o_Data,
    output logic                          o_config_enable,
    output logic                          o_busy,
    output logic                          o_cfg_done,
    output logic                          o_configured
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_LOAD      = 2'd1;
    localparam logic [1:0] c_FINISH    = 2'd2;
    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_ADDR_LAST = 4'd15;

    logic [1:0]  r_state;
    logic [15:0] r_shadow;
    logic [3:0]  r_hold;
    logic [3:0]  r_addr;
    logic        r_data;
    logic        r_enable;
    logic        r_busy;
    logic        r_done;
    logic        r_configured;
    logic        r_ready;

    logic        w_hold_end;
    logic        w_addr_last;
    logic [3:0]  w_addr_next;

    assign w_hold_end  = (r_hold == c_HOLD_LAST);
    assign w_addr_last = (r_addr == c_ADDR_LAST);
    assign w_addr_next = r_addr + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_IDLE;
            r_shadow     <= 16'h0000;
            r_hold       <= 4'd0;
            r_addr       <= 4'd0;
            r_data       <= 1'b0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_configured <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cfg.i_cfg_valid) begin
                        // Shadow and first data bit come from the same word on the accept edge.
                        r_state  <= c_LOAD;
                        r_shadow <= cfg.i_cfg_word;
                        r_hold   <= 4'd0;
                        r_addr   <= 4'd0;
                        r_data   <= cfg.i_cfg_word[0];
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                    end
                end

                c_LOAD: begin
                    if (i_abort) begin
                        // Abort outranks completion, even on the final hold cycle.
                        r_state      <= c_IDLE;
                        r_hold       <= 4'd0;
                        r_addr       <= 4'd0;
                        r_data       <= 1'b0;
                        r_enable     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_configured <= 1'b0;
                        r_ready      <= 1'b1;
                    end else if (w_hold_end) begin
                        r_hold <= 4'd0;
                        if (w_addr_last) begin
                            r_state      <= c_FINISH;
                            r_addr       <= 4'd0;
                            r_data       <= 1'b0;
                            r_enable     <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_configured <= 1'b1;
                        end else begin
                            r_addr <= w_addr_next;
                            r_data <= r_shadow[w_addr_next];
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end

                c_FINISH: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state  <= c_IDLE;
                    r_hold   <= 4'd0;
                    r_addr   <= 4'd0;
                    r_data   <= 1'b0;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign cfg.o_cfg_ready  = r_ready;
    assign o_addr_load_data = r_addr;
    assign o_Data           = r_data;
    assign o_config_enable  = r_enable;
    assign o_busy           = r_busy;
    assign o_cfg_done       = r_done;
    assign o_configured     = r_configured;

endmodule
`default_nettype wire
